count_sweep_ctrl: RTL
=====================

Name: count_sweep_ctrl

Overview:
- Sequencer for the up/down counter datapath (en/up control, max/min tick status).
- Drives the counter's enable and direction to run a programmed number of sweeps: up-only, down-only, or ping-pong.
- Paces steps with a prescaler and reports progress through a start/busy/done handshake.
- Sits between a host/control FSM and one counter instance.

Parameters:
- SweepW, 8, width of the sweep-count register and sweep target.
- PreW, 8, width of the prescaler reload value.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- start_i  input  1  begin run; sampled only in IDLE.
- stop_i  input  1  abort run; ignored in IDLE.
- mode_i  input  2  00 up-only, 01 down-only, 10 ping-pong up-first, 11 ping-pong down-first.
- sweeps_i  input  SweepW  number of sweeps; 0 = run until stop.
- prescale_i  input  PreW  step slot every prescale_i+1 cycles.
- max_tick_i  input  1  counter at maximum.
- min_tick_i  input  1  counter at zero.
- cnt_en_o  output  1  counter enable.
- cnt_up_o  output  1  counter direction, 1 = up.
- busy_o  output  1  run in progress.
- done_o  output  1  one-cycle completion pulse.
- sweep_cnt_o  output  SweepW  sweeps completed in current/last run.

Behaviour:
- Interface: one clock clk_i; reset rst_ni is asynchronous, active-low.
- Reset: state IDLE; prescaler, sweep_cnt_o, latched config = 0; busy_o = 0, done_o = 0, cnt_en_o = 0, cnt_up_o = 0. Reset mid-run aborts immediately; no done pulse.
- States: IDLE, UP, DOWN.
- IDLE + start_i:
  - Latch mode_i, sweeps_i, prescale_i; clear sweep_cnt_o; load prescaler with 0.
  - Enter UP (modes 00, 10) or DOWN (modes 01, 11).
  - First step slot is the first cycle in UP/DOWN.
- Step slot: prescaler == 0. Prescaler then reloads the latched prescale; otherwise it decrements.
- cnt_up_o = 1 in UP, 0 in DOWN and IDLE (registered from state).
- cnt_en_o is Mealy: asserted only in a slot, per the rules below, and forced 0 when stop_i = 1. The counter updates on the same edge as the controller.
- UP slot:
  - max_tick_i = 0: cnt_en_o = 1.
  - max_tick_i = 1, up-only: cnt_en_o = 1 (wrap to 0); sweep complete.
  - max_tick_i = 1, ping-pong: cnt_en_o = 0; sweep complete; next state DOWN.
- DOWN slot: mirror of UP using min_tick_i (down-only wraps to max).
- Sweep complete: sweep_cnt_o increments (wraps at 2^SweepW).
  - If latched sweeps != 0 and the new count equals it: go to IDLE and set done_o for exactly the next cycle.
  - The final slot's cnt_en_o (wrap) is still issued.
- busy_o = 1 exactly while in UP/DOWN. It falls on the same cycle done_o rises.
- stop_i in UP/DOWN: no cnt_en_o that cycle; IDLE next cycle; no done pulse; sweep_cnt_o holds its value.
- stop_i has priority over a coincident sweep completion.
- start_i while busy: ignored.
- Config inputs changing mid-run: no effect.
- done_o and start_i on the same cycle: the new run starts.

Optional Feature:
- Macro SWEEP_HOLD_EN.
- Defined: adds port hold_i (input, 1). While hold_i = 1 in UP/DOWN:
  - Prescaler frozen; cnt_en_o = 0; no sweep progress.
  - busy_o stays 1.
  - stop_i still aborts.
  - Release resumes with the frozen prescaler value.
- Undefined: port absent; behaviour as if hold_i = 0.

Test Plan (counter Width=3, i.e. max 7, starting at 0):
1. Up-only, sweeps=2, prescale=0, start -> cnt_en_o high 16 consecutive cycles; count 0..7,0..7,0; done_o pulse the cycle after the 16th enable; sweep_cnt_o=2; busy_o low with done_o.
2. Ping-pong up-first, sweeps=2, prescale=0 -> 7 up enables to count 7; one slot with no enable; 7 down enables to 0; no enable in slot 16; done_o next cycle; count 0.
3. Up-only, sweeps=1, prescale=3 -> enables on cycles 0,4,8,… after entering UP; 8 enables total; done_o 1 cycle after the 8th.
4. Up-only, sweeps=0, stop_i after 5 enables -> count 5; busy_o low next cycle; no done_o; no further cnt_en_o; sweep_cnt_o=0.
5. rst_ni low mid-run in DOWN -> busy_o, cnt_en_o, cnt_up_o, sweep_cnt_o = 0 asynchronously; start_i pulses while busy are ignored (sweep_cnt_o is not cleared).
6. SWEEP_HOLD_EN, up-only, prescale=0, hold_i high 10 cycles after 3 enables -> no enables during hold; count stays 3; resumes next cycle after release; total enables to done is unchanged.

Source files
------------

// File: rtl/count_sweep_ctrl.sv
// Sweep sequencer for an up/down counter: runs up-only, down-only or ping-pong sweeps paced by a prescaler.
// Optional `SWEEP_HOLD_EN adds hold_i, which freezes pacing and sweep progress while a run stays busy.
module count_sweep_ctrl #(
  parameter int SweepW = 8,
  parameter int PreW   = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic [1:0]        mode_i,
  input  logic [SweepW-1:0] sweeps_i,
  input  logic [PreW-1:0]   prescale_i,
  input  logic              max_tick_i,
  input  logic              min_tick_i,
`ifdef SWEEP_HOLD_EN
  input  logic              hold_i,
`endif
  output logic              cnt_en_o,
  output logic              cnt_up_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [SweepW-1:0] sweep_cnt_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              pingpong_q, pingpong_d;
  logic [SweepW-1:0] sweeps_q, sweeps_d;
  logic [PreW-1:0]   pre_cfg_q, pre_cfg_d;
  logic [PreW-1:0]   pre_q, pre_d;
  logic [SweepW-1:0] sweep_cnt_q, sweep_cnt_d;
  logic              done_q, done_d;

  logic hold_w;
  logic slot_w;
  logic at_end_w;

`ifdef SWEEP_HOLD_EN
  assign hold_w = hold_i;
`else
  assign hold_w = 1'b0;
`endif

  assign slot_w   = (pre_q == '0);
  assign at_end_w = (state_q == UP) ? max_tick_i : min_tick_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      pingpong_q  <= 1'b0;
      sweeps_q    <= '0;
      pre_cfg_q   <= '0;
      pre_q       <= '0;
      sweep_cnt_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pingpong_q  <= pingpong_d;
      sweeps_q    <= sweeps_d;
      pre_cfg_q   <= pre_cfg_d;
      pre_q       <= pre_d;
      sweep_cnt_q <= sweep_cnt_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pingpong_d  = pingpong_q;
    sweeps_d    = sweeps_q;
    pre_cfg_d   = pre_cfg_q;
    pre_d       = pre_q;
    sweep_cnt_d = sweep_cnt_q;
    done_d      = 1'b0;
    cnt_en_o    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          pingpong_d  = mode_i[1];
          sweeps_d    = sweeps_i;
          pre_cfg_d   = prescale_i;
          pre_d       = '0;
          sweep_cnt_d = '0;
          state_d     = mode_i[0] ? DOWN : UP;
        end
      end
      UP, DOWN: begin
        if (stop_i) begin
          state_d = IDLE;
        end else if (!hold_w) begin
          pre_d = slot_w ? pre_cfg_q : pre_q - 1'b1;
          if (slot_w) begin
            if (!at_end_w) begin
              cnt_en_o = 1'b1;
            end else begin
              // Single-direction modes wrap through the end; ping-pong turns around instead.
              cnt_en_o    = !pingpong_q;
              sweep_cnt_d = sweep_cnt_q + 1'b1;
              if (pingpong_q) begin
                state_d = (state_q == UP) ? DOWN : UP;
              end
              if ((sweeps_q != '0) && (sweep_cnt_d == sweeps_q)) begin
                state_d = IDLE;
                done_d  = 1'b1;
              end
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cnt_up_o    = (state_q == UP);
  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;
  assign sweep_cnt_o = sweep_cnt_q;

endmodule
